// File: rtl/ex_mem_pkg.sv
// Shared constants, state encoding and payload-width helper for the EX/MEM skid register.
package ex_mem_pkg;

  localparam int BR_BIT = 0;
  localparam int MR_BIT = 1;
  localparam int MW_BIT = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Packed entry layout: {wb, m[2:0], jump, br_target, zf, alu, wdata, rd}
  function automatic int calc_payload_w(input int xlen, input int ra_w, input int wb_w);
    return wb_w + 3 + 1 + xlen + 1 + xlen + xlen + ra_w;
  endfunction

endpackage

// File: rtl/ex_mem_skid_reg_if.sv
// Handshake and payload bundle between the EX stage, the EX/MEM register and the MEM stage.
interface ex_mem_skid_reg_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int WB_W = 2
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [WB_W-1:0] wb_in;
  logic [2:0]      m_in;
  logic            jump_in;
  logic [XLEN-1:0] br_target_in;
  logic            zf_in;
  logic [XLEN-1:0] alu_in;
  logic [XLEN-1:0] wdata_in;
  logic [RA_W-1:0] rd_in;

  logic            out_valid;
  logic            out_ready;
  logic [WB_W-1:0] wb_out;
  logic            branch_out;
  logic            memread_out;
  logic            memwrite_out;
  logic            jump_out;
  logic [XLEN-1:0] br_target_out;
  logic            zf_out;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] wdata_out;
  logic [RA_W-1:0] rd_out;

  modport slave (
    input  flush, in_valid, wb_in, m_in, jump_in, br_target_in, zf_in, alu_in, wdata_in, rd_in,
    input  out_ready,
    output in_ready, out_valid, wb_out, branch_out, memread_out, memwrite_out, jump_out,
    output br_target_out, zf_out, alu_out, wdata_out, rd_out
  );

  modport master (
    output flush, in_valid, wb_in, m_in, jump_in, br_target_in, zf_in, alu_in, wdata_in, rd_in,
    output out_ready,
    input  in_ready, out_valid, wb_out, branch_out, memread_out, memwrite_out, jump_out,
    input  br_target_out, zf_out, alu_out, wdata_out, rd_out
  );
endinterface

// File: rtl/ex_mem_skid_reg_skid_buf.sv
// Generic P-wide 2-entry skid buffer with registered ready and synchronous flush.
module skid_buf
  import ex_mem_pkg::*;
#(
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [P-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [P-1:0] o_data
);

  skid_state_e r_state;
  skid_state_e w_state_next;
  logic         r_ready;
  logic [P-1:0] r_main;
  logic [P-1:0] r_skid;
  logic         w_acc;
  logic         w_pop;
  logic         w_ld_main_in;
  logic         w_ld_main_skid;
  logic         w_ld_skid;

  assign o_valid = (r_state != EMPTY);
  assign o_ready = r_ready;
  assign o_data  = r_main;
  assign w_acc   = i_valid & r_ready;
  assign w_pop   = o_valid & i_ready;

  always_comb begin
    w_state_next   = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (i_flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            w_state_next = ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_acc && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_acc) begin
            w_state_next = FULL;
            w_ld_skid    = 1'b1;
          end else if (w_pop) begin
            w_state_next = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_state_next   = ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  // Ready is a flop so EX never sees a combinational path from MEM's ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next != FULL);
      if (w_ld_main_in) begin
        r_main <= i_data;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= i_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with valid/ready skid buffering, flush and bubble control gating.
// Optional EX_MEM_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module ex_mem_skid_reg
  import ex_mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int WB_W = 2
) (
  input  logic                 clkEXMEM,
  input  logic                 rstEXMEM_n,
  ex_mem_skid_reg_if.slave     bus
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  localparam int P = calc_payload_w(XLEN, RA_W, WB_W);

  logic [P-1:0]    w_pkt_in;
  logic [P-1:0]    w_pkt_out;
  logic            w_out_valid;
  logic            w_in_ready;
  logic [WB_W-1:0] w_wb;
  logic [2:0]      w_m;
  logic            w_jump;
  logic [XLEN-1:0] w_br_target;
  logic            w_zf;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_wdata;
  logic [RA_W-1:0] w_rd;

  assign w_pkt_in = {bus.wb_in, bus.m_in, bus.jump_in, bus.br_target_in, bus.zf_in,
                     bus.alu_in, bus.wdata_in, bus.rd_in};
  assign {w_wb, w_m, w_jump, w_br_target, w_zf, w_alu, w_wdata, w_rd} = w_pkt_out;

  skid_buf #(
    .P(P)
  ) u_skid_buf (
    .clk     (clkEXMEM),
    .rst_n   (rstEXMEM_n),
    .i_flush (bus.flush),
    .i_valid (bus.in_valid),
    .o_ready (w_in_ready),
    .i_data  (w_pkt_in),
    .o_valid (w_out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_pkt_out)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;

  // Control is masked by valid so a bubble can never write memory or the register file.
  assign bus.wb_out       = w_wb & {WB_W{w_out_valid}};
  assign bus.branch_out   = w_m[BR_BIT] & w_out_valid;
  assign bus.memread_out  = w_m[MR_BIT] & w_out_valid;
  assign bus.memwrite_out = w_m[MW_BIT] & w_out_valid;
  assign bus.jump_out     = w_jump & w_out_valid;

  assign bus.br_target_out = w_br_target;
  assign bus.zf_out        = w_zf;
  assign bus.alu_out       = w_alu;
  assign bus.wdata_out     = w_wdata;
  assign bus.rd_out        = w_rd;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clkEXMEM or negedge rstEXMEM_n) begin
    if (!rstEXMEM_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_out_valid && !bus.out_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      // Main is always valid whenever any entry is held.
      if (bus.flush && w_out_valid) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed-vector bench for ex_mem_skid_reg: reset, streaming, back-pressure, flush, gating.
module tb_ex_mem_skid_reg;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  ex_mem_skid_reg_if #(.XLEN(32), .RA_W(5), .WB_W(2)) bus ();

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  ex_mem_skid_reg #(.XLEN(32), .RA_W(5), .WB_W(2)) dut (
    .clkEXMEM   (clk),
    .rstEXMEM_n (rst_n),
    .bus        (bus.slave)
`ifdef EX_MEM_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] alu, input logic [2:0] m, input logic [1:0] wb);
    bus.in_valid     = v;
    bus.alu_in       = alu;
    bus.m_in         = m;
    bus.wb_in        = wb;
    bus.br_target_in = alu + 32'h1000;
    bus.wdata_in     = ~alu;
    bus.rd_in        = alu[4:0];
    bus.zf_in        = (alu == 32'd0);
    bus.jump_in      = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 32'd0, 3'b000, 2'b00);

    // Reset state
    repeat (2) tick();
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_alu_out", {32'd0, bus.alu_out}, 64'd0);
    chk("rst_wb_out", {62'd0, bus.wb_out}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Streaming: 8 back-to-back with out_ready high
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_in(1'b1, i, 3'b000, 2'b01);
      tick();
      chk($sformatf("stream_valid_%0d", i), {63'd0, bus.out_valid}, 64'd1);
      chk($sformatf("stream_alu_%0d", i), {32'd0, bus.alu_out}, i);
      chk($sformatf("stream_ready_%0d", i), {63'd0, bus.in_ready}, 64'd1);
    end
    drive_in(1'b0, 32'd0, 3'b000, 2'b00);
    tick();
    chk("stream_drain_valid", {63'd0, bus.out_valid}, 64'd0);

    // Back-pressure: fill to FULL, then drain in order
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h11, 3'b000, 2'b00);
    tick();
    chk("bp_A_alu", {32'd0, bus.alu_out}, 64'h11);
    chk("bp_A_ready", {63'd0, bus.in_ready}, 64'd1);
    drive_in(1'b1, 32'h22, 3'b000, 2'b00);
    tick();
    chk("bp_full_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_full_alu", {32'd0, bus.alu_out}, 64'h11);
    drive_in(1'b1, 32'hEE, 3'b000, 2'b00);
    tick();
    chk("bp_hold_alu", {32'd0, bus.alu_out}, 64'h11);
    chk("bp_hold_ready", {63'd0, bus.in_ready}, 64'd0);
    drive_in(1'b0, 32'h0, 3'b000, 2'b00);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_drain_B_alu", {32'd0, bus.alu_out}, 64'h22);
    chk("bp_drain_B_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("bp_drain_B_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("bp_drain_B_wdata", {32'd0, bus.wdata_out}, {32'd0, ~32'h22});
    tick();
    chk("bp_drain_empty", {63'd0, bus.out_valid}, 64'd0);

    // Flush while FULL with C presented
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h44, 3'b011, 2'b10);
    tick();
    drive_in(1'b1, 32'h55, 3'b011, 2'b10);
    tick();
    chk("fl_pre_branch", {63'd0, bus.branch_out}, 64'd1);
    chk("fl_pre_wb", {62'd0, bus.wb_out}, 64'd2);
    drive_in(1'b1, 32'h33, 3'b011, 2'b10);
    bus.flush = 1'b1;
    tick();
    chk("fl_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("fl_branch", {63'd0, bus.branch_out}, 64'd0);
    chk("fl_memread", {63'd0, bus.memread_out}, 64'd0);
    chk("fl_alu_kept", {32'd0, bus.alu_out}, 64'h44);
    chk("fl_ready", {63'd0, bus.in_ready}, 64'd1);
    // Flush from EMPTY also drops a same-cycle accept
    drive_in(1'b1, 32'h66, 3'b011, 2'b10);
    tick();
    chk("fl_acc_drop_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("fl_acc_drop_alu", {32'd0, bus.alu_out}, 64'h44);
    bus.flush = 1'b0;
    drive_in(1'b0, 32'h0, 3'b000, 2'b00);
    tick();
    chk("fl_after_valid", {63'd0, bus.out_valid}, 64'd0);

    // Bubble gating
    drive_in(1'b1, 32'h77, 3'b110, 2'b11);
    tick();
    chk("gate_memwrite_on", {63'd0, bus.memwrite_out}, 64'd1);
    chk("gate_memread_on", {63'd0, bus.memread_out}, 64'd1);
    chk("gate_branch_off", {63'd0, bus.branch_out}, 64'd0);
    drive_in(1'b0, 32'h0, 3'b000, 2'b00);
    bus.out_ready = 1'b1;
    tick();
    chk("gate_memwrite_off", {63'd0, bus.memwrite_out}, 64'd0);
    chk("gate_wb_off", {62'd0, bus.wb_out}, 64'd0);
    chk("gate_alu_kept", {32'd0, bus.alu_out}, 64'h77);
    chk("gate_rd_kept", {59'd0, bus.rd_out}, 64'h17);

    // Asynchronous reset mid-stream with two entries held
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h88, 3'b100, 2'b01);
    tick();
    drive_in(1'b1, 32'h99, 3'b100, 2'b01);
    tick();
    chk("mrst_pre_ready", {63'd0, bus.in_ready}, 64'd0);
    drive_in(1'b0, 32'h0, 3'b000, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mrst_memwrite", {63'd0, bus.memwrite_out}, 64'd0);
    chk("mrst_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("mrst_alu", {32'd0, bus.alu_out}, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("mrst_release_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mrst_release_ready", {63'd0, bus.in_ready}, 64'd1);

`ifdef EX_MEM_PERF_CNT_EN
    chk("perf_rst_stall", {32'd0, stall_cnt}, 64'd0);
    chk("perf_rst_flush", {32'd0, flush_cnt}, 64'd0);
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'hA1, 3'b000, 2'b00);
    tick();
    drive_in(1'b0, 32'h0, 3'b000, 2'b00);
    repeat (5) tick();
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'hA2, 3'b000, 2'b00);
    tick();
    drive_in(1'b0, 32'h0, 3'b000, 2'b00);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    tick();
    tick();
    bus.flush = 1'b0;
    chk("perf_stall_cnt", {32'd0, stall_cnt}, 64'd5);
    chk("perf_flush_cnt", {32'd0, flush_cnt}, 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Parametrised EX/MEM pipeline stage register for the MIPS datapath.
- Sits between the ALU stage and the data-memory stage.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from a multi-cycle data memory stalls EX without a combinational ready path.
- Adds a synchronous flush for branch/jump squash, and forces control fields to zero on bubbles.

Parameters:
- XLEN, 32, width of ALU result, store data and branch target.
- RA_W, 5, width of destination register index.
- WB_W, 2, width of write-back control field.

Ports:
- clkEXMEM  in  1  rising-edge clock.
- rstEXMEM_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  EX presents a valid instruction.
- in_ready  out  1  stage can accept; registered.
- wb_in  in  WB_W  write-back control.
- m_in  in  3  bit0 Branch, bit1 MemRead, bit2 MemWrite.
- jump_in  in  1  jump control.
- br_target_in  in  XLEN  branch target address.
- zf_in  in  1  ALU zero flag.
- alu_in  in  XLEN  ALU result.
- wdata_in  in  XLEN  store data.
- rd_in  in  RA_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM stage consumes head this cycle.
- wb_out, branch_out, memread_out, memwrite_out, jump_out  out  WB_W/1/1/1/1  control; all zero when out_valid=0.
- br_target_out, zf_out, alu_out, wdata_out, rd_out  out  XLEN/1/XLEN/XLEN/RA_W  payload of head entry.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- Payload width P = WB_W+3+1+XLEN+1+XLEN+XLEN+RA_W, packed internally.
- Reset (async assert, sync release):
  - both valid bits 0; all payload registers 0; in_ready=1; every output 0.
- Handshakes:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- States: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1). Skid valid with main invalid is illegal.
- EMPTY:
  - acc -> ONE, main <= input.
- ONE:
  - acc & pop -> ONE, main <= input.
  - acc & !pop -> FULL, skid <= input.
  - !acc & pop -> EMPTY.
  - else hold.
- FULL:
  - in_ready=0, so acc is impossible.
  - pop -> ONE, main <= skid.
  - else hold.
- in_ready is registered and equals !skid_valid of the next state, so it is deasserted the cycle after FULL is entered.
- Latency:
  - accepted data appears on outputs 1 cycle after acc when the stage was EMPTY or popping.
  - throughput 1/cycle with out_ready held high.
- Ordering is strictly FIFO; an entry is never dropped except by flush.
- flush:
  - next edge clears both valid bits and returns to EMPTY.
  - an input accepted in the same cycle is discarded.
  - a pop in the same cycle still counts as consumed by MEM.
  - payload registers are left unchanged.
- Priority: reset > flush > handshake.
- Control gating: branch_out/memread_out/memwrite_out/jump_out/wb_out = stored value AND out_valid, so bubbles never write memory or registers.
- Payload outputs show the main entry regardless of valid.
- No arithmetic; widths pass through unchanged.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- Defined:
  - adds outputs stall_cnt[31:0] and flush_cnt[31:0], reset to 0.
  - stall_cnt increments each cycle out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 while any entry is valid.
  - both wrap at 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package ex_mem_pkg:
  - M-field bit index constants BR_BIT=0, MR_BIT=1, MW_BIT=2.
  - state encoding typedef {EMPTY, ONE, FULL}.
  - localparam function computing P from XLEN/RA_W/WB_W.
- One sub-module: skid_buf (generic P-wide 2-entry skid buffer with flush).
- ex_mem_skid_reg handles packing/unpacking and control gating, plus the optional counters.

Test Plan:
- Reset mid-stream: load 2 entries, pull rstEXMEM_n low -> out_valid=0, memwrite_out=0, in_ready=1 immediately (async); state EMPTY after release.
- Streaming: out_ready=1, 8 back-to-back acc with alu_in=0..7 -> alu_out 0..7 in order, one per cycle, 1-cycle latency, in_ready stays 1.
- Back-pressure:
  - out_ready=0, push A=0x11, B=0x22 -> FULL, in_ready=0 next cycle, alu_out=0x11 held.
  - out_ready=1 -> 0x11 then 0x22, with no loss or duplication.
- Flush while FULL and in_valid=1 (C=0x33) -> next cycle out_valid=0, branch_out=0, memread_out=0; C never appears at alu_out.
- Bubble gating: m_in=3'b110 entry, then out_ready=1 with in_valid=0 -> memwrite_out=1 for one cycle, then memwrite_out=0 while alu_out retains the value.
- EX_MEM_PERF_CNT_EN: 5 cycles of out_valid & !out_ready plus 2 flushes with entries valid -> stall_cnt=5, flush_cnt=2.
